// File: rtl/shift_seq_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// shift_seq_ctrl_pkg
// Shared definitions for the multi-cycle shift sequencer and the DLX
// shift-unit wrappers:
//   - state_e   : sequencer state encoding (IDLE / SHIFT / DONE)
//   - WIDTH_DEF : default datapath width
//   - AMT_W_DEF : default shift-amount width
// Optional build macro used by the sequencer: SHIFT_FAST_EN (4-position steps).
// ---------------------------------------------------------------------------
package shift_seq_ctrl_pkg;

   localparam int WIDTH_DEF = 32;
   localparam int AMT_W_DEF = 5;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

endpackage

// File: rtl/shift_seq_ctrl_shift_step.sv
// ---------------------------------------------------------------------------
// shift_step
// Combinational single-step shifter used by the shift sequencer. Shifts the
// input by one position, or by four when four_i is set.
// Ports:
//   data_i  [WIDTH] value to shift
//   right_i         1 = shift right, 0 = shift left
//   arith_i         1 = sign fill on right shifts (ignored for left shifts)
//   four_i          1 = shift by four positions, 0 = by one
//   data_o  [WIDTH] shifted value
// ---------------------------------------------------------------------------
module shift_step
   import shift_seq_ctrl_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF
) (
   input  logic [WIDTH-1:0] data_i,
   input  logic             right_i,
   input  logic             arith_i,
   input  logic             four_i,
   output logic [WIDTH-1:0] data_o
);

   logic [2:0] shAmt;

   // Left and logical-right shifts fill with zero; the arithmetic right
   // shift replicates the sign bit into every vacated position, so a
   // four-position step keeps the same fill rule as four single steps.
   always_comb begin
      shAmt = four_i ? 3'd4 : 3'd1;
      if (!right_i) begin
         data_o = data_i << shAmt;
      end else if (arith_i) begin
         data_o = $unsigned($signed(data_i) >>> shAmt);
      end else begin
         data_o = data_i >> shAmt;
      end
   end

endmodule

// File: rtl/shift_seq_ctrl.sv
// ---------------------------------------------------------------------------
// shift_seq_ctrl
// Multi-cycle shift sequencer. A shift of N positions is carried out as N
// successive single-position steps through shift_step, with a start/done
// handshake towards the requester.
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   start    request pulse, sampled only while busy=0
//   right    1 = right shift, 0 = left shift (latched at start)
//   arith    sign fill for right shifts (latched at start)
//   operand  [WIDTH] value to shift (latched at start)
//   amount   [AMT_W] number of positions (latched at start)
//   busy     high while steps are being applied
//   done     one-cycle pulse, result valid from this cycle on
//   result   [WIDTH] registered shifted value
// Build macro: SHIFT_FAST_EN - while at least four positions remain, one
// step moves four positions at once. Results are identical either way.
// ---------------------------------------------------------------------------
module shift_seq_ctrl
   import shift_seq_ctrl_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int AMT_W = AMT_W_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             right,
   input  logic             arith,
   input  logic [WIDTH-1:0] operand,
   input  logic [AMT_W-1:0] amount,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result
);

   state_e           state_q, state_d;
   logic [WIDTH-1:0] acc_q, acc_d;
   logic [AMT_W-1:0] cnt_q, cnt_d;
   logic             right_q, right_d;
   logic             arith_q, arith_d;
   logic [WIDTH-1:0] result_q, result_d;

   logic             fourStep;
   logic [AMT_W-1:0] stepAmt;
   logic [WIDTH-1:0] stepOut;

`ifdef SHIFT_FAST_EN
   assign fourStep = (cnt_q >= AMT_W'(4));
`else
   assign fourStep = 1'b0;
`endif
   assign stepAmt = fourStep ? AMT_W'(4) : AMT_W'(1);

   shift_step #(
      .WIDTH (WIDTH)
   ) u_step (
      .data_i  (acc_q),
      .right_i (right_q),
      .arith_i (arith_q),
      .four_i  (fourStep),
      .data_o  (stepOut)
   );

   // State, accumulator and counter registers. Reset clears everything,
   // including result, so an aborted shift leaves no stale value behind.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         acc_q    <= '0;
         cnt_q    <= '0;
         right_q  <= 1'b0;
         arith_q  <= 1'b0;
         result_q <= '0;
      end else begin
         state_q  <= state_d;
         acc_q    <= acc_d;
         cnt_q    <= cnt_d;
         right_q  <= right_d;
         arith_q  <= arith_d;
         result_q <= result_d;
      end
   end

   // Next-state logic. A request is accepted in IDLE and also in DONE so
   // requests can run back to back. The step that empties the counter is
   // the last one, so the sequencer goes straight to DONE after it.
   // result is loaded on the edge that enters DONE, which makes it valid
   // during the done pulse itself.
   always_comb begin
      state_d  = state_q;
      acc_d    = acc_q;
      cnt_d    = cnt_q;
      right_d  = right_q;
      arith_d  = arith_q;
      result_d = result_q;
      case (state_q)
         ST_IDLE, ST_DONE: begin
            state_d = ST_IDLE;
            if (start) begin
               acc_d   = operand;
               cnt_d   = amount;
               right_d = right;
               arith_d = arith;
               state_d = (amount != '0) ? ST_SHIFT : ST_DONE;
            end
         end
         ST_SHIFT: begin
            acc_d = stepOut;
            cnt_d = cnt_q - stepAmt;
            if (cnt_q == stepAmt) begin
               state_d = ST_DONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
      if (state_d == ST_DONE) begin
         result_d = acc_d;
      end
   end

   assign busy   = (state_q == ST_SHIFT);
   assign done   = (state_q == ST_DONE);
   assign result = result_q;

endmodule
